// File: rtl/fp_add_arbiter_pkg.sv
// fp_add_arbiter_pkg: shared FP16 width, default sizing and index-width helper
package fp_add_arbiter_pkg;
  localparam int FP16_W = 16;
  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF = 1;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/fp_add_arbiter_rr.sv
// rr_arbiter: one-hot round-robin pick, search starts at ptr and wraps modulo NREQ
//   req : request vector
//   ptr : index that gets first priority
//   gnt : one-hot winner, zero when no request
module rr_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);
  int idx;
  // walk from the farthest candidate back to ptr so the closest request wins
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      gnt = req[idx] ? NREQ'(1) << idx : gnt;
    end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one external FP16 adder among NREQ requesters
//   clk, reset           : clock, async active-high reset
//   req, op_a, op_b      : per-requester request and packed FP16 operands
//   freeze               : stalls issue and the adder pipeline
//   gnt                  : one-hot issue this cycle
//   add_en, add_a, add_b : adder enable and operands; add_q is its result
//   rsp_valid, rsp_q     : one-hot response owner and result
//   busy                 : any operation in flight
module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*FP16_W-1:0]   op_a,
  input  logic [NREQ*FP16_W-1:0]   op_b,
  input  logic                     freeze,
  output logic [NREQ-1:0]          gnt,
  output logic                     add_en,
  output logic [FP16_W-1:0]        add_a,
  output logic [FP16_W-1:0]        add_b,
  input  logic [FP16_W-1:0]        add_q,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [FP16_W-1:0]        rsp_q,
  output logic                     busy
);
  localparam int IW = clog2(NREQ);
  logic [IW-1:0] ptr, gidx;
  logic [NREQ-1:0] arb_gnt;
  logic grant;
  logic [LAT-1:0] tag_v;
  logic [IW-1:0] tag_id [LAT];
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (.req(req), .ptr(ptr), .gnt(arb_gnt));
  assign gnt = (reset | freeze) ? '0 : arb_gnt;
  assign grant = |gnt;
  assign busy = |tag_v;
  assign add_en = ~reset & ~freeze & (grant | busy);
  assign rsp_q = add_q;
  always_comb begin
    gidx = '0;
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      gidx = gnt[i] ? IW'(i) : gidx;
      add_a = gnt[i] ? op_a[FP16_W*i +: FP16_W] : add_a;
      add_b = gnt[i] ? op_b[FP16_W*i +: FP16_W] : add_b;
    end
  end
  always_comb begin
    rsp_valid = '0;
    if (!reset && !freeze && tag_v[LAT-1]) rsp_valid[tag_id[LAT-1]] = 1'b1;
  end
  // tags move in lockstep with the adder pipeline, so they only shift on add_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      tag_v <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      if (grant) ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      if (add_en) begin
        tag_v <= LAT'({tag_v, grant});
        for (int k = LAT - 1; k > 0; k--) tag_id[k] <= tag_id[k-1];
        tag_id[0] <= gidx;
      end
    end
  end
endmodule
